// File: rtl/interboard_tx_scheduler.sv
// rtl/interboard_tx_scheduler.sv - Request/Ack interboard transmit sequencer; build option INTERBOARD_PARITY_EN
module interboard_tx_scheduler #(
    parameter int         FIFO_DEPTH  = 4,
    parameter int         TIMEOUT_CYC = 65535,
    parameter logic [3:0] RST_TYPE    = 4'hF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ctrl_en,
    input  logic       ctrl_move_dir,
    input  logic [4:0] ctrl_block_x,
    input  logic [2:0] ctrl_block_y,
    input  logic [3:0] ctrl_msg_type,
    input  logic [5:0] ctrl_card,
    input  logic [2:0] ctrl_sel_len,
    input  logic       rst_bcast_req,
    input  logic       ack_in,
    output logic       req_out,
    output logic [5:0] data_out,
    output logic       data_oe,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow,
    output logic       timeout_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef INTERBOARD_PARITY_EN
    localparam int NF = 5;
`else
    localparam int NF = 4;
`endif
    localparam int SW = 6 * NF;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [23:0] BCAST_PAYLOAD = {2'b00, 1'b0, 5'd0, 3'd0, RST_TYPE, 6'd0, 3'd0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t        state_q, state_d;
    logic [21:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          bcast_pend_q, bcast_pend_d;
    logic          bcast_sel_q, bcast_sel_d;
    logic [SW-1:0] shreg_q, shreg_d;
    logic [2:0]    frame_q, frame_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          overflow_q, overflow_d;
    logic          timeout_err_q, timeout_err_d;
    logic          ack_s1_q, ack_s2_q;
    logic          push_en, pop_en, flush;
    logic [23:0]   payload;
    logic          ack_sync;

    assign ack_sync    = ack_s2_q;
    assign fifo_full   = (count_q == (AW+1)'(FIFO_DEPTH));
    assign req_out     = (state_q == S_WAIT_HI);
    assign data_oe     = (state_q != S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign overflow    = overflow_q;
    assign timeout_err = timeout_err_q;
    assign data_out    = (state_q == S_SETUP || state_q == S_WAIT_HI || state_q == S_WAIT_LO)
                         ? shreg_q[SW-1 -: 6] : 6'd0;

    // Next-state logic: arbitration, queue bookkeeping, frame handshake and timeouts
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        bcast_pend_d  = bcast_pend_q | rst_bcast_req;
        bcast_sel_d   = bcast_sel_q;
        shreg_d       = shreg_q;
        frame_d       = frame_q;
        tmo_d         = tmo_q;
        overflow_d    = ctrl_en && fifo_full;
        timeout_err_d = 1'b0;
        push_en       = ctrl_en && !fifo_full;
        pop_en        = 1'b0;
        flush         = 1'b0;
        payload       = 24'h0;
        case (state_q)
            S_IDLE: begin
                if (bcast_pend_q) begin
                    // Broadcast supersedes everything queued, including this cycle's ctrl_en
                    flush        = 1'b1;
                    bcast_pend_d = 1'b0;
                    bcast_sel_d  = 1'b1;
                    state_d      = S_LOAD;
                end else if (count_q != '0 || ctrl_en) begin
                    bcast_sel_d = 1'b0;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                payload = bcast_sel_q ? BCAST_PAYLOAD : {2'b00, mem_q[rd_ptr_q]};
                pop_en  = !bcast_sel_q;
`ifdef INTERBOARD_PARITY_EN
                shreg_d = {payload, payload[23:18] ^ payload[17:12] ^ payload[11:6] ^ payload[5:0]};
`else
                shreg_d = payload;
`endif
                frame_d = 3'd0;
                state_d = S_SETUP;
            end
            S_SETUP: begin
                tmo_d   = '0;
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (ack_sync) begin
                    tmo_d   = '0;
                    state_d = S_WAIT_LO;
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_WAIT_LO: begin
                if (!ack_sync) begin
                    if (frame_q == 3'(NF - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        shreg_d = shreg_q << 6;
                        frame_d = frame_q + 3'd1;
                        state_d = S_SETUP;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            push_en  = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
        end
    end

    // Message storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= {ctrl_move_dir, ctrl_block_x, ctrl_block_y,
                                ctrl_msg_type, ctrl_card, ctrl_sel_len};
        end
    end

    // State, queue pointers, shifter, counters and the Ack synchronizer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            bcast_pend_q  <= 1'b0;
            bcast_sel_q   <= 1'b0;
            shreg_q       <= '0;
            frame_q       <= 3'd0;
            tmo_q         <= '0;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            ack_s1_q      <= 1'b0;
            ack_s2_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            bcast_pend_q  <= bcast_pend_d;
            bcast_sel_q   <= bcast_sel_d;
            shreg_q       <= shreg_d;
            frame_q       <= frame_d;
            tmo_q         <= tmo_d;
            overflow_q    <= overflow_d;
            timeout_err_q <= timeout_err_d;
            ack_s1_q      <= ack_in;
            ack_s2_q      <= ack_s1_q;
        end
    end

endmodule

// File: tb/tb_interboard_tx_scheduler.sv
// tb/tb_interboard_tx_scheduler.sv - self-checking bench for interboard_tx_scheduler
module tb_interboard_tx_scheduler;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;
`ifdef INTERBOARD_PARITY_EN
    localparam int NF = 5;
`else
    localparam int NF = 4;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       ctrl_en;
    logic       ctrl_move_dir;
    logic [4:0] ctrl_block_x;
    logic [2:0] ctrl_block_y;
    logic [3:0] ctrl_msg_type;
    logic [5:0] ctrl_card;
    logic [2:0] ctrl_sel_len;
    logic       rst_bcast_req;
    logic       ack_in = 1'b0;
    logic       req_out;
    logic [5:0] data_out;
    logic       data_oe;
    logic       busy;
    logic       fifo_full;
    logic       overflow;
    logic       timeout_err;

    interboard_tx_scheduler #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT_CYC(TMO),
        .RST_TYPE   (4'hF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ctrl_en      (ctrl_en),
        .ctrl_move_dir(ctrl_move_dir),
        .ctrl_block_x (ctrl_block_x),
        .ctrl_block_y (ctrl_block_y),
        .ctrl_msg_type(ctrl_msg_type),
        .ctrl_card    (ctrl_card),
        .ctrl_sel_len (ctrl_sel_len),
        .rst_bcast_req(rst_bcast_req),
        .ack_in       (ack_in),
        .req_out      (req_out),
        .data_out     (data_out),
        .data_oe      (data_oe),
        .busy         (busy),
        .fifo_full    (fifo_full),
        .overflow     (overflow),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: payload from field values by place-value arithmetic
    function automatic logic [23:0] pack(input int dir, input int x, input int y,
                                         input int t, input int card, input int len);
        int v;
        v = dir * (1 << 21) + x * (1 << 16) + y * (1 << 13) + t * (1 << 9) + card * 8 + len;
        return 24'(v);
    endfunction

    // Reference: the concatenation of all frames expected on the link for one payload
    function automatic logic [29:0] frames_of(input logic [23:0] p);
        int unsigned v;
        int unsigned f;
        int unsigned par;
        logic [29:0] r;
        v   = 32'(p);
        r   = '0;
        par = 0;
        for (int i = 0; i < 4; i++) begin
            f   = (v >> (18 - 6 * i)) % 64;
            r   = (r << 6) | 30'(f);
            par = par ^ f;
        end
`ifdef INTERBOARD_PARITY_EN
        r = (r << 6) | 30'(par);
`endif
        return r;
    endfunction

    // Loopback responder: Ack follows Request two cycles late when enabled
    logic ack_en = 1'b0;
    logic ack_d1 = 1'b0;
    logic ack_d2 = 1'b0;
    always @(negedge clk) begin
        ack_in = ack_en & ack_d2;
        ack_d2 = ack_d1;
        ack_d1 = req_out;
    end

    // Link monitor: capture a frame on each Request rise, group NF frames per message
    logic [29:0] cur = '0;
    int          cur_n = 0;
    int          req_rises = 0;
    logic        prev_req = 1'b0;
    logic [29:0] obs_q[$];
    logic [29:0] exp_q[$];
    always @(negedge clk) begin
        if (rst || timeout_err) begin
            cur   = '0;
            cur_n = 0;
        end else if (req_out && !prev_req) begin
            cur = (cur << 6) | 30'(data_out);
            cur_n++;
            req_rises++;
            if (cur_n == NF) begin
                obs_q.push_back(cur);
                cur   = '0;
                cur_n = 0;
            end
        end
        prev_req = req_out;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_fields(input logic [23:0] p);
        ctrl_move_dir = p[21];
        ctrl_block_x  = p[20:16];
        ctrl_block_y  = p[15:13];
        ctrl_msg_type = p[12:9];
        ctrl_card     = p[8:3];
        ctrl_sel_len  = p[2:0];
    endtask

    task automatic send(input logic [23:0] p);
        drive_fields(p);
        ctrl_en = 1'b1;
        tick();
        ctrl_en = 1'b0;
    endtask

    task automatic wait_msgs(input string tag, input int n);
        int c;
        c = 0;
        while (obs_q.size() < n && c < 3000) begin
            tick();
            c++;
        end
        chk(tag, 32'(c < 3000), 32'd1);
    endtask

    task automatic settle(input string tag);
        int c;
        c = 0;
        while (busy && c < 3000) begin
            tick();
            c++;
        end
        repeat (30) tick();
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk($sformatf("%s_msg%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"},  32'(req_out),     32'd0);
        chk({tag, "_data"}, 32'(data_out),    32'd0);
        chk({tag, "_oe"},   32'(data_oe),     32'd0);
        chk({tag, "_busy"}, 32'(busy),        32'd0);
        chk({tag, "_full"}, 32'(fifo_full),   32'd0);
        chk({tag, "_ovf"},  32'(overflow),    32'd0);
        chk({tag, "_tmo"},  32'(timeout_err), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [23:0] p;
        logic [29:0] fr;
        int          cyc;
        int          c;

        rst           = 1'b1;
        ctrl_en       = 1'b0;
        rst_bcast_req = 1'b0;
        drive_fields(24'h0);
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Directed message with loopback Ack: latency, frames, pulse count
        ack_en    = 1'b1;
        req_rises = 0;
        p         = pack(1, 17, 2, 3, 42, 3);
        fr        = frames_of(p);
        send(p);
        chk("t1_load_busy", 32'(busy), 32'd1);
        chk("t1_load_oe",   32'(data_oe), 32'd1);
        chk("t1_load_req",  32'(req_out), 32'd0);
        tick();
        chk("t1_setup_data", 32'(data_out), 32'((p >> 18) % 64));
        chk("t1_setup_req",  32'(req_out), 32'd0);
        tick();
        chk("t1_req_rise", 32'(req_out), 32'd1);
        chk("t1_data_hold", 32'(data_out), 32'((p >> 18) % 64));
        exp_q.push_back(fr);
        wait_msgs("t1_done", 1);
        settle("t1_idle");
        chk("t1_req_pulses", 32'(req_rises), 32'(NF));
        chk("t1_oe_idle", 32'(data_oe), 32'd0);
        check_stream("t1");

        // Queue fill with Ack held low, overflow, then ack timeout on the in-flight message
        ack_en = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            p = 24'($urandom) & 24'h3FFFFF;
            if (k >= 2 && k <= 5) exp_q.push_back(frames_of(p));
            send(p);
            chk($sformatf("t2_full_%0d", k), 32'(fifo_full), 32'(k >= 5));
            chk($sformatf("t2_ovf_%0d", k),  32'(overflow),  32'(k >= 6));
        end
        tick();
        chk("t2_ovf_clear", 32'(overflow), 32'd0);
        cyc = 7;
        while (!timeout_err && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("t2_tmo_cycle", 32'(cyc), 32'(3 + TMO));
        chk("t2_tmo_req",   32'(req_out), 32'd0);
        chk("t2_tmo_oe",    32'(data_oe), 32'd0);
        tick();
        chk("t2_tmo_pulse", 32'(timeout_err), 32'd0);
        ack_en = 1'b1;
        wait_msgs("t2_drain", 4);
        settle("t2_idle");
        check_stream("t2");

        // Broadcast requested mid-message with two queued: queue is flushed
        p = 24'($urandom) & 24'h3FFFFF;
        exp_q.push_back(frames_of(p));
        send(p);
        repeat (3) tick();
        send(24'($urandom) & 24'h3FFFFF);
        send(24'($urandom) & 24'h3FFFFF);
        rst_bcast_req = 1'b1;
        tick();
        rst_bcast_req = 1'b0;
        repeat (4) tick();
        rst_bcast_req = 1'b1;
        tick();
        rst_bcast_req = 1'b0;
        exp_q.push_back(frames_of(pack(0, 0, 0, 15, 0, 0)));
        wait_msgs("t3_done", 2);
        settle("t3_idle");
        chk("t3_empty", 32'(fifo_full), 32'd0);
        check_stream("t3");

        // Random messages with random gaps
        for (int k = 0; k < 5; k++) begin
            p = 24'($urandom) & 24'h3FFFFF;
            exp_q.push_back(frames_of(p));
            send(p);
            repeat ($urandom_range(0, 12)) tick();
        end
        wait_msgs("t4_done", 5);
        settle("t4_idle");
        check_stream("t4");

        // Reset while waiting for Ack low on the third frame
        send(24'($urandom) & 24'h3FFFFF);
        send(24'($urandom) & 24'h3FFFFF);
        c = 0;
        while (!(cur_n == 3 && !req_out && busy) && c < 1000) begin
            tick();
            c++;
        end
        chk("t5_reach", 32'(c < 1000), 32'd1);
        rst = 1'b1;
        tick();
        check_all_zero("t5_rst");
        rst = 1'b0;
        repeat (60) tick();
        chk("t5_nothing_sent", 32'(obs_q.size()), 32'd0);
        chk("t5_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
